// File: rtl/move_list_drain.sv
// Reader end of the column move FIFOs: drains columns 0..NCOL-1, unpacks 19-bit move slots,
// and hands legal-candidate moves downstream one per handshake. MOVE_DRAIN_STATS_EN adds cap_count.
module move_list_drain #(
    parameter int NCOL  = 8,
    parameter int SLOTS = 8,
    parameter int MOVW  = 19
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NCOL-1:0]            col_empty,
    input  logic [NCOL*SLOTS*MOVW-1:0] col_data,
    output logic [NCOL-1:0]            col_rden,
    output logic                       mov_valid,
    input  logic                       mov_ready,
    output logic [MOVW-1:0]            mov_data,
    output logic [7:0]                 mov_count,
    output logic                       busy,
    output logic                       all_done
`ifdef MOVE_DRAIN_STATS_EN
    ,
    output logic [7:0]                 cap_count
`endif
);

    localparam int WORDW    = SLOTS * MOVW;
    localparam int CW       = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int SW       = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int FLAG_INV = MOVW - 1;
    localparam int FLAG_CAP = MOVW - 7;

    typedef enum logic [2:0] {IDLE, WAITC, READ, LAT, UNPK, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [WORDW-1:0]  word_q;
    logic [MOVW-1:0]   cur_move;
    logic              is_inv, is_end;
    logic              load_word, clr_stats, accept;

    // End marker and invalid slot share the inv flag; from==to distinguishes them.
    always_comb begin
        cur_move = word_q[slot_q*MOVW +: MOVW];
        is_inv   = cur_move[FLAG_INV];
        is_end   = is_inv && (cur_move[11:6] == cur_move[5:0]);
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        slot_d    = slot_q;
        col_rden  = '0;
        mov_valid = 1'b0;
        load_word = 1'b0;
        clr_stats = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = WAITC;
                    col_d     = '0;
                    clr_stats = 1'b1;
                end
            end
            WAITC: begin
                if (!col_empty[col_q]) state_d = READ;
            end
            READ: begin
                col_rden[col_q] = 1'b1;
                state_d         = LAT;
            end
            LAT: begin
                load_word = 1'b1;
                slot_d    = '0;
                state_d   = UNPK;
            end
            UNPK: begin
                if (is_end) begin
                    if (col_q == CW'(NCOL - 1)) begin
                        state_d = DONE;
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = WAITC;
                    end
                end else begin
                    mov_valid = !is_inv;
                    accept    = !is_inv && mov_ready;
                    if (is_inv || mov_ready) begin
                        // Word exhausted without an end marker: fetch the next word of this column.
                        if (slot_q == SW'(SLOTS - 1)) state_d = WAITC;
                        else                           slot_d  = slot_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        mov_data = mov_valid ? cur_move : '0;
        busy     = (state_q != IDLE) && (state_q != DONE);
        all_done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            slot_q    <= '0;
            word_q    <= '0;
            mov_count <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            slot_q  <= slot_d;
            if (load_word) word_q <= col_data[col_q*WORDW +: WORDW];
            if (clr_stats)                     mov_count <= '0;
            else if (accept && mov_count != '1) mov_count <= mov_count + 1'b1;
        end
    end

`ifdef MOVE_DRAIN_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_count <= '0;
        end else if (clr_stats) begin
            cap_count <= '0;
        end else if (accept && cur_move[FLAG_CAP] && cap_count != '1) begin
            cap_count <= cap_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_move_list_drain.sv
// Directed bench for move_list_drain: column FIFO model plus expected-move scoreboard.
module tb_move_list_drain;

    localparam int NCOL  = 8;
    localparam int SLOTS = 8;
    localparam int MOVW  = 19;
    localparam int WW    = SLOTS * MOVW;
    localparam logic [MOVW-1:0] ENDM = 19'h40000;

    logic                 clk = 1'b0;
    logic                 reset, start, mov_ready;
    logic [NCOL-1:0]      col_empty;
    logic [NCOL*WW-1:0]   col_data;
    logic [NCOL-1:0]      col_rden;
    logic                 mov_valid, busy, all_done;
    logic [MOVW-1:0]      mov_data;
    logic [7:0]           mov_count;
`ifdef MOVE_DRAIN_STATS_EN
    logic [7:0]           cap_count;
`endif

    always #5 clk = ~clk;

    move_list_drain #(.NCOL(NCOL), .SLOTS(SLOTS), .MOVW(MOVW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .col_empty (col_empty),
        .col_data  (col_data),
        .col_rden  (col_rden),
        .mov_valid (mov_valid),
        .mov_ready (mov_ready),
        .mov_data  (mov_data),
        .mov_count (mov_count),
        .busy      (busy),
`ifdef MOVE_DRAIN_STATS_EN
        .cap_count (cap_count),
`endif
        .all_done  (all_done)
    );

    logic [WW-1:0]   fq [NCOL][$];
    logic [MOVW-1:0] exp_q [$];
    int              npass  = 0;
    int              ntotal = 0;
    int              rd0    = 0;
    logic            prev_hold = 1'b0;
    logic [MOVW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Runs at the negedge: FIFO pops on read enables and scoreboard compares on handshakes.
    task automatic service();
        if (!reset) begin
            prev_hold = 1'b0;
            return;
        end
        if (col_rden != '0) begin
            check("rden_onehot", 32'($onehot(col_rden)), 32'd1);
            for (int c = 0; c < NCOL; c++) begin
                if (col_rden[c]) begin
                    check("rden_nonempty", 32'(col_empty[c]), 32'd0);
                    if (fq[c].size() > 0) col_data[c*WW +: WW] = fq[c].pop_front();
                    col_empty[c] = (fq[c].size() == 0);
                    if (c == 0) rd0++;
                end
            end
        end
        if (prev_hold) begin
            check("valid_hold", 32'(mov_valid), 32'd1);
            check("data_hold", 32'(mov_data), 32'(prev_data));
        end
        if (mov_valid && mov_ready) begin
            if (exp_q.size() == 0) check("extra_move", 32'(mov_valid & mov_ready), 32'd0);
            else                   check("mov_data", 32'(mov_data), 32'(exp_q.pop_front()));
        end
        prev_hold = mov_valid && !mov_ready;
        prev_data = mov_data;
    endtask

    task automatic tick();
        @(negedge clk);
        service();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input int c, input logic [WW-1:0] w);
        fq[c].push_back(w);
        col_empty[c] = 1'b0;
    endtask

    task automatic load_end(input int c);
        logic [WW-1:0] w;
        w = '0;
        w[MOVW-1:0] = ENDM;
        push_word(c, w);
    endtask

    task automatic load_ends(input int first, input int last);
        for (int c = first; c <= last; c++) load_end(c);
    endtask

    // n random valid moves packed in slot order, first capn flagged as captures, then an end marker.
    task automatic load_moves(input int c, input int n, input int capn);
        logic [WW-1:0]   w;
        logic [MOVW-1:0] m;
        int              s;
        w = '0;
        s = 0;
        for (int i = 0; i < n; i++) begin
            m = MOVW'($urandom);
            m[18] = 1'b0;
            m[12] = (i < capn);
            w[s*MOVW +: MOVW] = m;
            exp_q.push_back(m);
            s++;
            if (s == SLOTS) begin
                push_word(c, w);
                w = '0;
                s = 0;
            end
        end
        w[s*MOVW +: MOVW] = ENDM;
        push_word(c, w);
    endtask

    task automatic start_gen(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_clr"}, 32'(all_done), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!all_done && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_all_done"}, 32'(all_done), 32'd1);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!mov_valid && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(mov_valid), 32'd1);
    endtask

    initial begin
        logic [WW-1:0]   w;
        logic [MOVW-1:0] held;
        int              rd_base;

        reset     = 1'b0;
        start     = 1'b0;
        mov_ready = 1'b1;
        col_empty = '1;
        col_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rden", 32'(col_rden), 32'd0);
        check("rst_valid", 32'(mov_valid), 32'd0);
        check("rst_data", 32'(mov_data), 32'd0);
        check("rst_count", 32'(mov_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(all_done), 32'd0);
        reset = 1'b1;
        tick();

        // Single move then end marker in col 0, empty lists elsewhere.
        w = '0;
        w[18:0]  = 19'h04C1C;
        w[37:19] = ENDM;
        push_word(0, w);
        exp_q.push_back(19'h04C1C);
        load_ends(1, 7);
        start_gen("t1");
        wait_done("t1", 300);
        check("t1_count", 32'(mov_count), 32'd1);
        repeat (3) tick();
        check("t1_done_sticky", 32'(all_done), 32'd1);

        // Full word of 8 moves followed by a word whose slot 0 ends the list.
        rd_base = rd0;
        load_moves(0, 8, 0);
        load_ends(1, 7);
        start_gen("t2");
        wait_done("t2", 300);
        check("t2_count", 32'(mov_count), 32'd8);
        check("t2_rden0", 32'(rd0 - rd_base), 32'd2);

        // Backpressure: move must stay presented unchanged while ready is low.
        load_moves(0, 1, 0);
        load_ends(1, 7);
        mov_ready = 1'b0;
        start_gen("t3");
        wait_valid("t3", 50);
        held = mov_data;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stable", 32'(mov_data), 32'(held));
        end
        check("t3_count_hold", 32'(mov_count), 32'd0);
        mov_ready = 1'b1;
        wait_done("t3", 300);
        check("t3_count", 32'(mov_count), 32'd1);

        // Invalid slots skipped; no read while col 0 is empty.
        load_ends(1, 7);
        rd_base = rd0;
        start_gen("t4");
        repeat (10) tick();
        check("t4_no_read", 32'(rd0 - rd_base), 32'd0);
        check("t4_waiting", 32'(busy), 32'd1);
        w = '0;
        w[0*MOVW +: MOVW] = 19'h40040;
        w[1*MOVW +: MOVW] = 19'h40081;
        w[2*MOVW +: MOVW] = 19'h400C5;
        w[3*MOVW +: MOVW] = 19'h01234;
        w[4*MOVW +: MOVW] = ENDM;
        push_word(0, w);
        exp_q.push_back(19'h01234);
        wait_done("t4", 300);
        check("t4_count", 32'(mov_count), 32'd1);

        // Reset while presenting a col 3 move, then a clean restart from col 0.
        load_ends(0, 2);
        load_moves(3, 4, 0);
        mov_ready = 1'b0;
        start_gen("t5");
        wait_valid("t5", 100);
        reset = 1'b0;
        #1;
        check("t5_rst_valid", 32'(mov_valid), 32'd0);
        check("t5_rst_data", 32'(mov_data), 32'd0);
        check("t5_rst_rden", 32'(col_rden), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(all_done), 32'd0);
        check("t5_rst_count", 32'(mov_count), 32'd0);
        for (int c = 0; c < NCOL; c++) fq[c].delete();
        exp_q.delete();
        col_empty = '1;
        mov_ready = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("t5_idle", 32'(busy), 32'd0);
        load_moves(0, 3, 0);
        load_ends(1, 7);
        start_gen("t5b");
        wait_done("t5b", 300);
        check("t5b_count", 32'(mov_count), 32'd3);

        // Ten moves across two words, three of them captures.
        load_moves(0, 10, 3);
        load_ends(1, 7);
        start_gen("t6");
        wait_done("t6", 300);
        check("t6_count", 32'(mov_count), 32'd10);
`ifdef MOVE_DRAIN_STATS_EN
        check("t6_cap", 32'(cap_count), 32'd3);
`endif

        // More than 255 moves: counter saturates.
        load_moves(0, 260, 0);
        load_ends(1, 7);
        start_gen("t7");
        wait_done("t7", 2000);
        check("t7_sat", 32'(mov_count), 32'd255);
`ifdef MOVE_DRAIN_STATS_EN
        check("t7_cap_clr", 32'(cap_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
